// File: rtl/hamming_pkg.sv
// Shared types, codeword bit positions and helpers for the SECDED (8,4) link.
// Used by the syndrome generator and the receive decoder pipeline.
package hamming_pkg;

  typedef enum logic [1:0] {
    HAM_OK,
    HAM_SEC,
    HAM_DED
  } ham_status_t;

  localparam int P0 = 0;
  localparam int P2 = 1;
  localparam int P1 = 2;
  localparam int D0 = 3;
  localparam int P3 = 4;
  localparam int D1 = 5;
  localparam int D2 = 6;
  localparam int D3 = 7;

  typedef struct packed {
    logic [7:0] cw;
    logic [3:0] syn;
  } s1_t;

  typedef struct packed {
    logic [3:0] data;
    logic [7:0] cw_corr;
    logic [3:0] syn;
    logic       single;
    logic       dbl;
  } s2_t;

  // P1 and P2 sit at swapped positions, so syndromes 1 and 2
  // do not equal their bit index.
  function automatic logic [2:0] syn_to_bit(input logic [2:0] syn);
    logic [2:0] b;
    unique case (syn)
      3'd0:    b = 3'(P0);
      3'd1:    b = 3'(P1);
      3'd2:    b = 3'(P2);
      default: b = syn;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/hamming_secded_syndrome.sv
// Combinational SECDED (8,4) syndrome: cw[7:0] -> syn = {g,s3,s2,s1}.
// Ports: cw (codeword in), syn (overall parity + 3-bit Hamming syndrome).
module hamming_secded_syndrome
  import hamming_pkg::*;
(
  input  logic [7:0] cw,
  output logic [3:0] syn
);

  assign syn[0] = cw[P1] ^ cw[D0] ^ cw[D1] ^ cw[D3];
  assign syn[1] = cw[P2] ^ cw[D0] ^ cw[D2] ^ cw[D3];
  assign syn[2] = cw[P3] ^ cw[D1] ^ cw[D2] ^ cw[D3];
  assign syn[3] = ^cw;

endmodule

// File: rtl/hamming_secded_decoder_pipe.sv
// Two-stage SECDED (8,4) receive decoder with valid/ready backpressure.
// Ports: clk, rst_n (sync low), in_* stream, out_* stream, cnt_clr, cnt_*.
module hamming_secded_decoder_pipe
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_cw,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic [7:0]       out_cw_corr,
  output logic [3:0]       out_syndrome,
  output logic             out_single,
  output logic             out_double,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_single,
  output logic [CNT_W-1:0] cnt_double
);

  logic        s1_valid;
  logic        s2_valid;
  s1_t         s1_d;
  s1_t         s1_q;
  s2_t         s2_d;
  s2_t         s2_q;
  logic        adv1;
  logic        adv2;
  logic        fire;
  ham_status_t st;
  logic [7:0]  mask;
  logic [7:0]  c;
  logic [3:0]  in_syn;

  logic [CNT_W-1:0] cs_q;
  logic [CNT_W-1:0] cd_q;

  assign adv2     = !s2_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;
  assign fire     = s2_valid && out_ready;

  hamming_secded_syndrome u_syn (
    .cw  (in_cw),
    .syn (in_syn)
  );

  assign s1_d.cw  = in_cw;
  assign s1_d.syn = in_syn;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  always_comb begin
    st   = HAM_OK;
    mask = '0;
    unique case (1'b1)
      s1_q.syn[3]: begin
        st   = HAM_SEC;
        mask = 8'(1) << syn_to_bit(s1_q.syn[2:0]);
      end
      (!s1_q.syn[3] && |s1_q.syn[2:0]): st = HAM_DED;
      default: st = HAM_OK;
    endcase
    c = s1_q.cw ^ mask;
    s2_d.data    = {c[D3], c[D2], c[D1], c[D0]};
    s2_d.cw_corr = c;
    s2_d.syn     = s1_q.syn;
    s2_d.single  = (st == HAM_SEC);
    s2_d.dbl     = (st == HAM_DED);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_q     <= '0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_q <= s2_d;
    end
  end

  assign out_valid    = s2_valid;
  assign out_data     = s2_q.data;
  assign out_cw_corr  = s2_q.cw_corr;
  assign out_syndrome = s2_q.syn;
  assign out_single   = s2_q.single;
  assign out_double   = s2_q.dbl;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_q <= '0;
      cd_q <= '0;
    end else if (cnt_clr) begin
      cs_q <= '0;
      cd_q <= '0;
    end else begin
      if (fire && s2_q.single && !(&cs_q))
        cs_q <= cs_q + CNT_W'(1);
      if (fire && s2_q.dbl && !(&cd_q))
        cd_q <= cd_q + CNT_W'(1);
    end
  end

  assign cnt_single = cs_q;
  assign cnt_double = cd_q;

endmodule

// File: tb/tb_hamming_secded_decoder_pipe.sv
// Self-checking bench for hamming_secded_decoder_pipe (CNT_W=2).
// Table vectors plus backpressure, saturation, clear and reset sequences.
module tb_hamming_secded_decoder_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_cw;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [7:0] out_cw_corr;
  logic [3:0] out_syndrome;
  logic       out_single;
  logic       out_double;
  logic       cnt_clr;
  logic [1:0] cnt_single;
  logic [1:0] cnt_double;
  logic [3:0] lb_syn;

  always #5 clk = ~clk;

  hamming_secded_decoder_pipe #(.CNT_W(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_cw        (in_cw),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_cw_corr  (out_cw_corr),
    .out_syndrome (out_syndrome),
    .out_single   (out_single),
    .out_double   (out_double),
    .cnt_clr      (cnt_clr),
    .cnt_single   (cnt_single),
    .cnt_double   (cnt_double)
  );

  hamming_secded_syndrome lb (
    .cw  (out_cw_corr),
    .syn (lb_syn)
  );

  typedef struct packed {
    logic [7:0] cw;
    logic [3:0] data;
    logic [7:0] corr;
    logic [3:0] syn;
    logic       single;
    logic       dbl;
  } vec_t;

  vec_t tbl[10];
  vec_t strm[16];
  vec_t q[$];
  vec_t idle_v;
  int   occ;
  int   n_chk;
  int   n_fail;
  int   m_s;
  int   m_d;
  bit   hold;
  logic [3:0] h_data;
  logic [7:0] h_corr;
  logic [3:0] h_syn;
  logic       h_s;
  logic       h_d;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  function automatic logic [7:0] enc(input logic [3:0] d);
    logic [7:0] c;
    c = '0;
    c[3] = d[0];
    c[5] = d[1];
    c[6] = d[2];
    c[7] = d[3];
    c[2] = d[0] ^ d[1] ^ d[3];
    c[1] = d[0] ^ d[2] ^ d[3];
    c[4] = d[1] ^ d[2] ^ d[3];
    c[0] = ^c[7:1];
    return c;
  endfunction

  function automatic logic [2:0] pos_syn(input int i);
    logic [2:0] s;
    case (i)
      0:       s = 3'd0;
      1:       s = 3'd2;
      2:       s = 3'd1;
      default: s = 3'(i);
    endcase
    return s;
  endfunction

  function automatic vec_t mk(input logic [3:0] d, input int nerr,
                              input int i, input int j);
    vec_t v;
    logic [7:0] c;
    c        = enc(d);
    v.cw     = c;
    v.corr   = c;
    v.data   = d;
    v.syn    = 4'h0;
    v.single = 1'b0;
    v.dbl    = 1'b0;
    if (nerr == 1) begin
      v.cw     = c ^ (8'(1) << i);
      v.syn    = {1'b1, pos_syn(i)};
      v.single = 1'b1;
    end else if (nerr == 2) begin
      v.cw   = c ^ (8'(1) << i) ^ (8'(1) << j);
      v.corr = v.cw;
      v.syn  = {1'b0, pos_syn(i) ^ pos_syn(j)};
      v.dbl  = 1'b1;
      v.data = {v.cw[7], v.cw[6], v.cw[5], v.cw[3]};
    end
    return v;
  endfunction

  // One clock: drive at negedge, check #1 later, then wait a full cycle.
  task automatic cycle(input bit iv, input vec_t v, input bit ordy,
                       input bit clr, output bit acc);
    vec_t e;
    in_valid  = iv;
    in_cw     = v.cw;
    out_ready = ordy;
    cnt_clr   = clr;
    #1;
    chk("in_ready", in_ready, (occ == 2 && !ordy) ? 0 : 1);
    chk("cnt_single", cnt_single, m_s);
    chk("cnt_double", cnt_double, m_d);
    if (hold) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, h_data);
      chk("hold_corr", out_cw_corr, h_corr);
      chk("hold_syn", out_syndrome, h_syn);
      chk("hold_single", out_single, h_s);
      chk("hold_double", out_double, h_d);
    end
    hold = out_valid && !ordy;
    if (hold) begin
      h_data = out_data;
      h_corr = out_cw_corr;
      h_syn  = out_syndrome;
      h_s    = out_single;
      h_d    = out_double;
    end
    if (out_valid && ordy) begin
      if (q.size() == 0) begin
        chk("unexpected_word", q.size(), 1);
      end else begin
        e = q.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_cw_corr", out_cw_corr, e.corr);
        chk("out_syndrome", out_syndrome, e.syn);
        chk("out_single", out_single, e.single);
        chk("out_double", out_double, e.dbl);
        if (!e.dbl) chk("loopback_syn", lb_syn, 0);
        occ--;
        if (e.single && m_s < 3) m_s++;
        if (e.dbl && m_d < 3) m_d++;
      end
    end
    if (clr) begin
      m_s = 0;
      m_d = 0;
    end
    acc = iv && in_ready;
    if (acc) begin
      q.push_back(v);
      occ++;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    bit a;
    for (int k = 0; k < 40 && occ > 0; k++) cycle(0, idle_v, 1, 0, a);
    chk("drain_empty", occ, 0);
  endtask

  task automatic model_reset();
    q.delete();
    occ  = 0;
    m_s  = 0;
    m_d  = 0;
    hold = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit   a;
    int   idx;
    int   nerr;
    int   ei;
    int   ej;
    vec_t v;

    n_chk  = 0;
    n_fail = 0;
    idle_v = '0;
    tbl[0] = '{8'hAC, 4'hB, 8'hAC, 4'h0, 1'b0, 1'b0};
    tbl[1] = '{8'h8C, 4'hB, 8'hAC, 4'hD, 1'b1, 1'b0};
    tbl[2] = '{8'h01, 4'h0, 8'h00, 4'h8, 1'b1, 1'b0};
    tbl[3] = '{8'hCC, 4'hD, 8'hCC, 4'h3, 1'b0, 1'b1};
    tbl[4] = '{8'hAE, 4'hB, 8'hAC, 4'hA, 1'b1, 1'b0};
    tbl[5] = '{8'hA8, 4'hB, 8'hAC, 4'h9, 1'b1, 1'b0};
    tbl[6] = '{8'hBC, 4'hB, 8'hAC, 4'hC, 1'b1, 1'b0};
    tbl[7] = '{8'h2D, 4'h3, 8'h2D, 4'h7, 1'b0, 1'b1};
    tbl[8] = '{8'hFF, 4'hF, 8'hFF, 4'h0, 1'b0, 1'b0};
    tbl[9] = '{8'h00, 4'h0, 8'h00, 4'h0, 1'b0, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_cw     = '0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_corr", out_cw_corr, 0);
    chk("rst_out_syn", out_syndrome, 0);
    chk("rst_flags", {out_single, out_double}, 0);
    chk("rst_cnts", {cnt_single, cnt_double}, 0);

    // Latency: accepted at edge 1, visible after edge 2.
    cycle(1, tbl[0], 1, 0, a);
    chk("lat_accept", a, 1);
    chk("lat_valid_1", out_valid, 0);
    cycle(0, idle_v, 1, 0, a);
    chk("lat_valid_2", out_valid, 1);
    drain();

    // Table vectors streamed back to back.
    for (int i = 0; i < 10; i++) begin
      cycle(1, tbl[i], 1, 0, a);
      chk("tbl_accept", a, 1);
    end
    drain();

    // Backpressure stream of all 16 data words with 0/1/2-bit errors.
    for (int d = 0; d < 16; d++) begin
      nerr    = $urandom_range(0, 2);
      ei      = $urandom_range(0, 7);
      ej      = (ei + 1 + $urandom_range(0, 6)) % 8;
      strm[d] = mk(4'(d), nerr, ei, ej);
    end
    idx = 0;
    for (int k = 0; k < 400 && idx < 16; k++) begin
      cycle($urandom_range(0, 2) != 0, strm[idx],
            $urandom_range(0, 1) == 1, 0, a);
      if (a) idx++;
    end
    chk("stream_done", idx, 16);
    drain();

    // Saturation at 3 with five SEC words.
    cycle(0, idle_v, 1, 1, a);
    v = mk(4'h6, 1, 5, 0);
    for (int i = 0; i < 5; i++) cycle(1, v, 1, 0, a);
    drain();
    cycle(0, idle_v, 1, 0, a);
    chk("sat_single", cnt_single, 3);

    // Clear in the same cycle as a delivered SEC word.
    cycle(1, v, 0, 0, a);
    cycle(0, idle_v, 0, 0, a);
    chk("clr_pending_valid", out_valid, 1);
    cycle(0, idle_v, 1, 1, a);
    chk("clr_wins", cnt_single, 0);

    // Deliver one DED word, then fill both stages and reset.
    cycle(1, tbl[3], 1, 0, a);
    drain();
    cycle(0, idle_v, 0, 0, a);
    chk("ded_cnt", cnt_double, 1);
    cycle(1, tbl[1], 0, 0, a);
    cycle(1, tbl[7], 0, 0, a);
    #1;
    chk("full_in_ready", in_ready, 0);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_cnt_d", cnt_double, 0);
    chk("mid_rst_cnt_s", cnt_single, 0);
    chk("mid_rst_ready", in_ready, 1);
    cycle(1, tbl[8], 1, 0, a);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
